// File: rtl/bin2tri_conv_pkg.sv
// Shared ternary helpers for the binary-to-ternary converter: trit encoding,
// conditional trit negation, sign of a binary word, and the converter FSM states.
package bin2tri_conv_pkg;

  localparam logic [1:0] TRIT_Z = 2'b00;
  localparam logic [1:0] TRIT_P = 2'b01;
  localparam logic [1:0] TRIT_M = 2'b11;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } conv_state_t;

  // Swaps +1 and -1 when neg is set; zero is its own negation.
  function automatic logic [1:0] util_trit_neg_cond(input logic [1:0] t, input logic neg);
    logic [1:0] r;
    r = t;
    if (neg) begin
      if (t == TRIT_P) r = TRIT_M;
      else if (t == TRIT_M) r = TRIT_P;
    end
    return r;
  endfunction

  function automatic logic [1:0] util_bin_sign(input logic msb, input logic nonzero);
    logic [1:0] r;
    r = TRIT_Z;
    if (msb) r = TRIT_M;
    else if (nonzero) r = TRIT_P;
    return r;
  endfunction

endpackage

// File: rtl/bin2tri_div3_step.sv
// One balanced-ternary digit step: emits the low trit of mag and the
// magnitude that remains after removing it.
module bin2tri_div3_step
  import bin2tri_conv_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] mag,
  output logic [1:0]   trit,
  output logic [W-1:0] mag_next
);

  logic [W-1:0] q;
  logic [W-1:0] rem;

  assign q   = mag / W'(3);
  assign rem = mag - q * W'(3);

  // For r=2, (mag+1)/3 equals q+1, which never exceeds 2^W/3 and so cannot wrap.
  always_comb begin
    trit     = TRIT_Z;
    mag_next = q;
    if (rem == W'(1)) begin
      trit = TRIT_P;
    end else if (rem == W'(2)) begin
      trit     = TRIT_M;
      mag_next = q + W'(1);
    end
  end

endmodule

// File: rtl/bin2tri_conv.sv
// Sequential two's-complement to balanced-ternary converter: one trit per
// cycle on |bin|, sign applied per trit, fixed N+2 cycle conversion.
module bin2tri_conv
  import bin2tri_conv_pkg::*;
#(
  parameter int N = 9,
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           e,
  input  logic [W-1:0]   bin,
  output logic           busy,
  output logic           o,
  output logic [2*N-1:0] res,
  output logic [1:0]     cf,
  output logic [1:0]     sf,
  output logic           ovf
);

  localparam int CNT_W = $clog2(N + 1);

  // Handshake: e is accepted only on an edge where busy=0; o is a one-cycle
  // pulse after the final step, and e in that same cycle starts the next job.
  conv_state_t      state;
  logic [W-1:0]     mag;
  logic             neg;
  logic [1:0]       sgn;
  logic [2*N-1:0]   sr;
  logic [CNT_W-1:0] cnt;

  logic [1:0]       step_trit;
  logic [W-1:0]     step_mag;
  logic [1:0]       trit_s;

  bin2tri_div3_step #(.W(W)) u_step (
    .mag      (mag),
    .trit     (step_trit),
    .mag_next (step_mag)
  );

  assign trit_s = util_trit_neg_cond(step_trit, neg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      mag   <= '0;
      neg   <= 1'b0;
      sgn   <= TRIT_Z;
      sr    <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      o     <= 1'b0;
      res   <= '0;
      cf    <= TRIT_Z;
      sf    <= TRIT_Z;
      ovf   <= 1'b0;
    end else begin
      o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (e) begin
            mag   <= bin[W-1] ? (~bin + W'(1)) : bin;
            neg   <= bin[W-1];
            sgn   <= util_bin_sign(bin[W-1], |bin);
            sr    <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          mag <= step_mag;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(N)) begin
            // Trits shift in from the top, so trit 0 lands in bits [1:0] after N steps.
            res   <= sr;
            cf    <= trit_s;
            sf    <= sgn;
            ovf   <= |step_mag;
            o     <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            sr <= {trit_s, sr[2*N-1:2]};
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2tri_conv.sv
// Directed bench for bin2tri_conv: a driver pushes hand-computed results into
// a queue and a negedge monitor pops and compares on every o pulse.
module tb_bin2tri_conv;

  localparam int N  = 9;
  localparam int W  = 16;
  localparam int EW = 2 * N + 5;

  logic           clk;
  logic           rst;
  logic           e;
  logic [W-1:0]   bin;
  logic           busy;
  logic           o;
  logic [2*N-1:0] res;
  logic [1:0]     cf;
  logic [1:0]     sf;
  logic           ovf;

  logic [EW-1:0] exp_q[$];
  int            cyc_q[$];
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  logic [EW-1:0] mon_exp;
  int            mon_cyc;

  bin2tri_conv #(.N(N), .W(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .e    (e),
    .bin  (bin),
    .busy (busy),
    .o    (o),
    .res  (res),
    .cf   (cf),
    .sf   (sf),
    .ovf  (ovf)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [EW-1:0] pk(input logic [2*N-1:0] r, input logic [1:0] c,
                                       input logic [1:0] s, input logic v);
    return {r, c, s, v};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Driver: presents e/bin for one edge; accepted starts record their result.
  task automatic start_conv(input logic [W-1:0] b, input logic accept, input logic [EW-1:0] ex);
    @(negedge clk);
    if (accept) begin
      exp_q.push_back(ex);
      cyc_q.push_back(cyc + N + 2);
    end
    e   = 1'b1;
    bin = b;
    @(negedge clk);
    e = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending results, required 0", exp_q.size());
      exp_q.delete();
      cyc_q.delete();
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst && o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_o: got o=1 at cycle %0d, required no pulse", cyc);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_cyc = cyc_q.pop_front();
        checks++;
        if ({res, cf, sf, ovf} !== mon_exp) begin
          errors++;
          $display("FAIL result: got res=%h cf=%b sf=%b ovf=%b, required res=%h cf=%b sf=%b ovf=%b",
                   res, cf, sf, ovf, mon_exp[EW-1:5], mon_exp[4:3], mon_exp[2:1], mon_exp[0]);
        end
        checks++;
        if (cyc != mon_cyc) begin
          errors++;
          $display("FAIL latency: got o at cycle %0d, required cycle %0d", cyc, mon_cyc);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    e   = 1'b0;
    bin = '0;
    repeat (3) @(negedge clk);
    check("rst_o", 32'(o), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_res", 32'(res), 32'd0);
    check("rst_flags", 32'({cf, sf, ovf}), 32'd0);
    rst = 1'b0;

    // bin=5 with busy held for the whole conversion
    start_conv(16'd5, 1'b1, pk(18'h0001F, 2'b00, 2'b01, 1'b0));
    for (int i = 0; i < N; i++) begin
      check("busy_run", 32'(busy), 32'd1);
      @(negedge clk);
    end
    wait_drain();

    start_conv(-16'sd5, 1'b1, pk(18'h00035, 2'b00, 2'b11, 1'b0));
    wait_drain();
    check("busy_idle", 32'(busy), 32'd0);
    start_conv(16'd0, 1'b1, pk(18'h00000, 2'b00, 2'b00, 1'b0));
    wait_drain();
    start_conv(16'd9841, 1'b1, pk(18'h15555, 2'b00, 2'b01, 1'b0));
    wait_drain();
    start_conv(16'd9842, 1'b1, pk(18'h3FFFF, 2'b01, 2'b01, 1'b0));
    wait_drain();
    start_conv(-16'sd29524, 1'b1, pk(18'h3FFFF, 2'b11, 2'b11, 1'b0));
    wait_drain();
    start_conv(16'h8000, 1'b1, pk(18'h10051, 2'b01, 2'b11, 1'b1));
    wait_drain();
    start_conv(16'd29525, 1'b1, pk(18'h3FFFF, 2'b11, 2'b01, 1'b1));
    wait_drain();

    // e during busy is ignored; e in the o cycle starts the next conversion
    start_conv(16'd5, 1'b1, pk(18'h0001F, 2'b00, 2'b01, 1'b0));
    @(negedge clk);
    start_conv(16'd7, 1'b0, '0);
    for (int i = 0; i < 30 && !o; i++) @(negedge clk);
    check("o_seen", 32'(o), 32'd1);
    exp_q.push_back(pk(18'h0001D, 2'b00, 2'b01, 1'b0));
    cyc_q.push_back(cyc + N + 2);
    e   = 1'b1;
    bin = 16'd7;
    @(negedge clk);
    e = 1'b0;
    wait_drain();

    // reset mid-conversion: no o pulse, outputs cleared
    start_conv(16'd1234, 1'b0, '0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_o", 32'(o), 32'd0);
    check("abort_res", 32'(res), 32'd0);
    check("abort_flags", 32'({cf, sf, ovf}), 32'd0);
    repeat (15) @(negedge clk);

    start_conv(-16'sd5, 1'b1, pk(18'h00035, 2'b00, 2'b11, 1'b0));
    wait_drain();
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bin2tri_conv.md
Name: bin2tri_conv

Overview:
- Sequential converter from a two's-complement binary word to an N-trit balanced-ternary word, plus a carry trit.
- Trit encoding is the codebase standard: 2'b00 = 0, 2'b01 = +1, 2'b11 = -1, least-significant trit in bits [1:0].
- Sits at the binary-to-ternary boundary in front of the tri arithmetic units, e.g. host/immediate/IO import.
- Produces one trit per cycle with fixed latency and the same e/o pulse handshake as the other multi-cycle ternary units.

Parameters:
- N, 9, number of result trits; res is 2*N bits wide.
- W, 16, width of the signed binary input.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- e  input  1  start pulse. bin is sampled on the edge where e=1 and busy=0.
- bin  input  W  signed two's-complement value to convert.
- busy  output  1  high while a conversion is in progress.
- o  output  1  one-cycle done pulse.
- res  output  2*N  balanced-ternary result, trits 0..N-1.
- cf  output  2  carry trit, i.e. trit N of the result.
- sf  output  2  sign trit of the converted value: 01 positive, 00 zero, 11 negative.
- ovf  output  1  value not representable in N+1 trits.

Behaviour:
- Reset values: o=0, busy=0, res=0, cf=0, sf=0, ovf=0, iteration counter=0. Reset applies with priority at any time.
- Reset mid-conversion aborts the conversion: no o pulse, and outputs take their reset values.
- States:
  - IDLE: busy=0. On e=1, capture mag=|bin| as a W-bit unsigned value (|-2^(W-1)| = 2^(W-1) fits), neg=bin[W-1], sgn=sign(bin). Clear the trit shift register, set cnt=0, go to RUN.
  - RUN: busy=1. At each edge perform one step on mag:
    - r = mag mod 3.
    - r=0: trit 0, mag <= mag/3.
    - r=1: trit +1, mag <= (mag-1)/3.
    - r=2: trit -1, mag <= (mag+1)/3. Compute mag+1 in W+1 bits.
    - Trit k is negated (+1<->-1) when neg=1 and stored at position k. cnt increments.
  - Step k=N is the carry trit. On that edge: load res with trits 0..N-1, cf with trit N, sf with sgn, ovf with (mag after step N != 0), assert o=1 and return to IDLE.
- Latency: e sampled at edge 0; steps at edges 1..N+1; o=1 during the cycle after edge N+1. Latency is fixed and data-independent.
- o is high for exactly one cycle. res/cf/sf/ovf update only on completion and hold until the next completion or reset.
- e while busy=1 is ignored; it does not restart or queue.
- e in the completion cycle (o=1, busy=0) starts a new conversion, so back-to-back throughput is one result per N+2 cycles.
- On overflow, res/cf hold the low N+1 trits of the conversion (truncated) and sf still reflects the true sign of bin.
- Zero input: all trits 0, sf=00, ovf=0.
- Representable range is +/-(3^(N+1)-1)/2, i.e. +/-29524 for N=9.

Decomposition:
- Shared utils header (existing): trit encoding constants TRIT_Z/TRIT_P/TRIT_M, conditional negation util_trit_neg_cond, and a sign-of-binary helper.
- Sub-module bin2tri_div3_step (combinational):
  - inputs: W-bit magnitude.
  - outputs: one trit and the next W-bit magnitude.
  - Keeps the divide-by-3 logic isolated and separately testable.

Test Plan:
- rst, then bin=5, e=1 for one cycle -> o=1 exactly 11 cycles later; res=18'h0001F (+1,-1,-1); cf=00; sf=01; ovf=0; busy high in between.
- bin=-5 -> res=18'h00035; cf=00; sf=11; ovf=0. bin=0 -> res=0, cf=00, sf=00, ovf=0.
- bin=9841 -> res=18'h15555, cf=00, sf=01. bin=9842 -> res=18'h3FFFF, cf=01, sf=01, ovf=0. bin=-29524 -> res=18'h3FFFF, cf=11, sf=11, ovf=0.
- bin=-32768 -> ovf=1, sf=11. bin=29525 -> ovf=1, sf=01.
- Start bin=5, pulse e again at cycle 3 with bin=7 -> single o, result for 5. Then e in the o cycle with bin=7 -> next o 11 cycles later with res=18'h0001D.
- Start a conversion, assert rst at cycle 4 -> no o pulse; busy=0 and all outputs 0 the cycle after rst.
